// File: rtl/window_feeder_if.sv
// Pixel stream from the raster source plus the start_/end_ handshake to the neuron.
// The feeder sits on the slave side; the source/neuron side uses master.
interface window_feeder_if #(
   parameter int DATA_W = 100
);
   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] win_0;
   logic [DATA_W-1:0] win_1;
   logic [DATA_W-1:0] win_2;
   logic [DATA_W-1:0] win_3;
   logic [DATA_W-1:0] win_4;
   logic [DATA_W-1:0] win_5;
   logic [DATA_W-1:0] win_6;
   logic [DATA_W-1:0] win_7;
   logic [DATA_W-1:0] win_8;
   logic              start_;
   logic              end_;

   modport master (
      output pix_in, pix_valid, end_,
      input  pix_ready, start_,
      input  win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8
   );

   modport slave (
      input  pix_in, pix_valid, end_,
      output pix_ready, start_,
      output win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8
   );
endinterface

// File: rtl/window_feeder.sv
// Buffers two raster lines, builds a 3x3 window per valid position and hands it to the
// 9-input neuron, stalling the pixel stream until the neuron reports done on end_.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   FILL    | accept pixels; a pixel at row>=2, col>=2 completes a window
//   ISSUE   | start_ high for one cycle, window frozen
//   WAIT_LO | wait for end_ low (discard stale done from previous run)
//   WAIT_HI | wait for end_ high; last window of frame pulses frame_done
module window_feeder #(
   parameter int DATA_W  = 100,
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   window_feeder_if.slave           bus,
   output logic [$clog2(IMG_H)-1:0] o_win_row,
   output logic [$clog2(IMG_W)-1:0] o_win_col,
   output logic                     o_frame_done,
   output logic                     o_err
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_FILL    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_LO = 2'd2;
   localparam logic [1:0] S_WAIT_HI = 2'd3;

   logic [1:0]        r_state;
   logic [RW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_win_row;
   logic [CW-1:0]     r_win_col;
   logic [TW-1:0]     r_tmr;
   logic              r_frame_done;
   logic              r_err;
   logic [DATA_W-1:0] r_win    [9];
   logic [DATA_W-1:0] r_lb_top [IMG_W];
   logic [DATA_W-1:0] r_lb_mid [IMG_W];

   logic              w_pix_ready;
   logic              w_accept;
   logic              w_win_pos;
   logic              w_last_win;
   logic              w_tmr_tc;
   logic [DATA_W-1:0] w_col_top;
   logic [DATA_W-1:0] w_col_mid;

   assign w_pix_ready = (r_state == S_FILL) && !i_rst;
   assign w_accept    = bus.pix_valid && w_pix_ready;
   assign w_win_pos   = (r_row >= RW'(2)) && (r_col >= CW'(2));
   assign w_last_win  = (r_win_row == ROW_LAST) && (r_win_col == COL_LAST);
   assign w_tmr_tc    = (r_tmr == '0);
   assign w_col_top   = r_lb_top[r_col];
   assign w_col_mid   = r_lb_mid[r_col];

   // Line buffers carry no reset: each column is rewritten before it reaches a window.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_lb_top[r_col] <= r_lb_mid[r_col];
         r_lb_mid[r_col] <= bus.pix_in;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_FILL;
         r_row        <= '0;
         r_col        <= '0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_tmr        <= '0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            r_win[k] <= '0;
         end
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_FILL: begin
               if (w_accept) begin
                  // Window registers only move on accept, so they stay frozen until FILL.
                  for (int i = 0; i < 3; i++) begin
                     r_win[3*i]   <= r_win[3*i+1];
                     r_win[3*i+1] <= r_win[3*i+2];
                  end
                  r_win[2] <= w_col_top;
                  r_win[5] <= w_col_mid;
                  r_win[8] <= bus.pix_in;
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
                  if (w_win_pos) begin
                     r_state   <= S_ISSUE;
                     r_win_row <= r_row;
                     r_win_col <= r_col;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT_LO;
               r_tmr   <= TMR_LOAD;
            end
            S_WAIT_LO: begin
               if (!bus.end_) begin
                  r_state <= S_WAIT_HI;
                  r_tmr   <= TMR_LOAD;
               end else if (w_tmr_tc) begin
                  r_err   <= 1'b1;
                  r_state <= S_FILL;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            S_WAIT_HI: begin
               if (bus.end_) begin
                  r_state      <= S_FILL;
                  r_frame_done <= w_last_win;
               end else if (w_tmr_tc) begin
                  r_err   <= 1'b1;
                  r_state <= S_FILL;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign bus.pix_ready = w_pix_ready;
   assign bus.start_    = (r_state == S_ISSUE) && !i_rst;
   assign bus.win_0     = r_win[0];
   assign bus.win_1     = r_win[1];
   assign bus.win_2     = r_win[2];
   assign bus.win_3     = r_win[3];
   assign bus.win_4     = r_win[4];
   assign bus.win_5     = r_win[5];
   assign bus.win_6     = r_win[6];
   assign bus.win_7     = r_win[7];
   assign bus.win_8     = r_win[8];

   assign o_win_row    = r_win_row;
   assign o_win_col    = r_win_col;
   assign o_frame_done = r_frame_done;
   assign o_err        = r_err;

endmodule

// File: tb/tb_window_feeder.sv
// Bench for window_feeder: image-array reference model, neuron model, scenario tasks.
module tb_window_feeder;
   localparam int DW = 100;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int TO = 64;

   typedef struct packed {
      logic [9*DW-1:0] w;
      logic [31:0]     r;
      logic [31:0]     c;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   window_feeder_if #(.DATA_W(DW)) bus ();
   logic [2:0] win_row;
   logic [2:0] win_col;
   logic       frame_done;
   logic       err;

   window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus),
      .o_win_row(win_row), .o_win_col(win_col),
      .o_frame_done(frame_done), .o_err(err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // neuron model: end_ drops right after start_, rises nm_delay cycles later
   logic nm_auto  = 1'b1;
   logic nm_end   = 1'b1;
   logic man_end  = 1'b0;
   int   nm_delay = 11;
   int   nm_cnt   = 0;
   assign bus.end_ = nm_auto ? nm_end : man_end;

   always @(posedge clk) begin
      #2;
      if (bus.start_) begin
         nm_end = 1'b0;
         nm_cnt = nm_delay;
      end else if (nm_cnt > 0) begin
         nm_cnt = nm_cnt - 1;
         if (nm_cnt == 0) nm_end = 1'b1;
      end
   end

   function automatic logic [9*DW-1:0] cur_win();
      return {bus.win_8, bus.win_7, bus.win_6, bus.win_5, bus.win_4,
              bus.win_3, bus.win_2, bus.win_1, bus.win_0};
   endfunction

   win_t obs_q[$];
   win_t exp_q[$];
   int   n_start = 0;
   int   n_fd    = 0;

   always @(negedge clk) begin
      if (bus.start_ === 1'b1) begin
         obs_q.push_back('{w: cur_win(), r: 32'(win_row), c: 32'(win_col)});
         n_start = n_start + 1;
      end
      if (frame_done === 1'b1) n_fd = n_fd + 1;
   end

   // reference model: raster image array, window read straight from it
   logic [DW-1:0] img [H][W];
   int pos_r = 0;
   int pos_c = 0;

   task automatic model_accept(input logic [DW-1:0] v);
      win_t e;
      img[pos_r][pos_c] = v;
      if (pos_r >= 2 && pos_c >= 2) begin
         e.w = '0;
         for (int k = 0; k < 9; k++)
            e.w[k*DW +: DW] = img[pos_r - 2 + k/3][pos_c - 2 + k%3];
         e.r = 32'(pos_r);
         e.c = 32'(pos_c);
         exp_q.push_back(e);
      end
      pos_c = pos_c + 1;
      if (pos_c == W) begin
         pos_c = 0;
         pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
      end
   endtask

   function automatic logic [DW-1:0] next_val(input bit ramp);
      logic [127:0] t;
      if (ramp) return DW'(pos_r * W + pos_c);
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // call at a negedge; returns at the negedge after the accepting edge
   task automatic push_pixel(input logic [DW-1:0] v);
      int budget;
      budget = 300;
      bus.pix_in    = v;
      bus.pix_valid = 1'b1;
      while (bus.pix_ready !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (bus.pix_ready !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_stall_bound pix_ready=%b required 1 within 300 cycles", bus.pix_ready);
      end
      @(negedge clk);
      model_accept(v);
   endtask

   task automatic send_pixels(input int n, input bit ramp, input int maxgap);
      int g;
      for (int i = 0; i < n; i++) begin
         push_pixel(next_val(ramp));
         if (maxgap > 0) begin
            g = $urandom_range(0, maxgap);
            if (g > 0) begin
               bus.pix_valid = 1'b0;
               repeat (g) @(negedge clk);
            end
         end
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic wait_frame_done(input int target);
      int b;
      b = 0;
      while (n_fd < target && b < 4000) begin
         @(negedge clk);
         b++;
      end
      repeat (3) @(negedge clk);
   endtask

   function automatic int rem_pixels();
      return (H - pos_r) * W - pos_c;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.pix_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pix_ready got=%b exp=0", bus.pix_ready); end
      n_checks++; if (bus.start_ !== 1'b0) begin n_errors++; $display("FAIL reset_start got=%b exp=0", bus.start_); end
      n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
      n_checks++; if (bus.win_0 !== '0 || bus.win_8 !== '0) begin n_errors++; $display("FAIL reset_win got0=%h got8=%h exp=0", bus.win_0, bus.win_8); end
      n_checks++; if (win_row !== 3'd0 || win_col !== 3'd0) begin n_errors++; $display("FAIL reset_rowcol got=%0d,%0d exp=0,0", win_row, win_col); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.pix_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.pix_ready); end
      @(negedge clk);
      pos_r = 0;
      pos_c = 0;
   endtask

   task automatic test_ramp_frame();
      int s0, f0, mism;
      obs_q.delete(); exp_q.delete();
      s0 = n_start; f0 = n_fd;
      nm_auto = 1'b1; nm_delay = 11;
      send_pixels(W * H, 1'b1, 0);
      wait_frame_done(f0 + 1);
      n_checks++; if (n_start - s0 !== 36) begin n_errors++; $display("FAIL ramp_start_count got=%0d exp=36", n_start - s0); end
      n_checks++; if (n_fd - f0 !== 1) begin n_errors++; $display("FAIL ramp_frame_done got=%0d exp=1", n_fd - f0); end
      n_checks++;
      if (obs_q.size() == 0) begin
         n_errors++; $display("FAIL ramp_first_window got=none exp=0/9/18");
      end else if (obs_q[0].w[0 +: DW] !== DW'(0) || obs_q[0].w[4*DW +: DW] !== DW'(9) ||
                   obs_q[0].w[8*DW +: DW] !== DW'(18) || obs_q[0].r !== 32'd2 || obs_q[0].c !== 32'd2) begin
         n_errors++;
         $display("FAIL ramp_first_window got w0=%0d w4=%0d w8=%0d at %0d,%0d exp 0/9/18 at 2,2",
                  obs_q[0].w[0 +: DW], obs_q[0].w[4*DW +: DW], obs_q[0].w[8*DW +: DW], obs_q[0].r, obs_q[0].c);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= obs_q.size()) begin
            n_errors++; $display("FAIL ramp_window_%0d got=missing exp=(%0d,%0d)", i, exp_q[i].r, exp_q[i].c);
         end else if (obs_q[i] !== exp_q[i]) begin
            n_errors++;
            $display("FAIL ramp_window_%0d got (%0d,%0d) w8=%0d exp (%0d,%0d) w8=%0d", i, obs_q[i].r, obs_q[i].c,
                     obs_q[i].w[8*DW +: DW], exp_q[i].r, exp_q[i].c, exp_q[i].w[8*DW +: DW]);
         end
      end
      mism = 0;
   endtask

   task automatic test_stall();
      int cyc, e_at, r_at, mism;
      bit changed;
      logic [9*DW-1:0] ref_w;
      logic [DW-1:0]   nv;
      obs_q.delete(); exp_q.delete();
      nm_auto = 1'b1; nm_delay = 11;
      send_pixels(2 * W + 2, 1'b0, 0);
      push_pixel(next_val(1'b0));
      nv = next_val(1'b0);
      bus.pix_in = nv;
      n_checks++; if (bus.start_ !== 1'b1 || bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL stall_issue start=%b ready=%b exp start=1 ready=0", bus.start_, bus.pix_ready); end
      ref_w = cur_win();
      cyc = 0; e_at = -1; r_at = -1; changed = 1'b0;
      while (cyc < 300 && r_at < 0) begin
         if (bus.pix_ready === 1'b1) r_at = cyc;
         else begin
            if (cur_win() !== ref_w) changed = 1'b1;
            if (bus.end_ === 1'b1 && e_at < 0) e_at = cyc;
            @(negedge clk);
            cyc++;
         end
      end
      n_checks++; if (e_at < 0 || r_at !== e_at + 1) begin n_errors++; $display("FAIL stall_ready_return got ready at %0d exp end_ cycle %0d + 1", r_at, e_at); end
      n_checks++; if (changed !== 1'b0 || cur_win() !== ref_w) begin n_errors++; $display("FAIL stall_window_stable changed=%b exp 0", changed); end
      @(negedge clk);
      model_accept(nv);
      bus.pix_valid = 1'b0;
      send_pixels(rem_pixels(), 1'b0, 0);
      wait_frame_done(n_fd + 1);
      mism = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      n_checks++; if (mism !== 0 || exp_q.size() !== 36) begin n_errors++; $display("FAIL stall_frame_windows got mism=%0d n=%0d exp mism=0 n=36", mism, obs_q.size()); end
   endtask

   task automatic test_stale_end();
      int s0, f0, mism;
      obs_q.delete(); exp_q.delete();
      f0 = n_fd;
      nm_auto = 1'b0; man_end = 1'b1;
      send_pixels(2 * W + 3, 1'b0, 0);
      s0 = n_start;
      n_checks++; if (bus.start_ !== 1'b1) begin n_errors++; $display("FAIL stale_issue start=%b exp 1", bus.start_); end
      repeat (10) @(negedge clk);
      n_checks++; if (bus.pix_ready !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL stale_held ready=%b err=%b exp 0,0", bus.pix_ready, err); end
      n_checks++; if (n_start - s0 !== 1) begin n_errors++; $display("FAIL stale_single_start got=%0d exp=1", n_start - s0); end
      man_end = 1'b0;
      @(negedge clk);
      man_end = 1'b1;
      n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL stale_wait_hi ready=%b exp 0", bus.pix_ready); end
      @(negedge clk);
      n_checks++; if (bus.pix_ready !== 1'b1) begin n_errors++; $display("FAIL stale_resume ready=%b exp 1", bus.pix_ready); end
      nm_auto = 1'b1;
      send_pixels(rem_pixels(), 1'b0, 0);
      wait_frame_done(f0 + 1);
      mism = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      n_checks++; if (mism !== 0 || n_fd - f0 !== 1) begin n_errors++; $display("FAIL stale_frame got mism=%0d fd=%0d exp 0,1", mism, n_fd - f0); end
   endtask

   task automatic test_timeout();
      int t, first_err, f0, mism;
      obs_q.delete(); exp_q.delete();
      f0 = n_fd;
      n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL timeout_pre_err got=%b exp 0", err); end
      nm_auto = 1'b0; man_end = 1'b0;
      send_pixels(2 * W + 3, 1'b0, 0);
      t = 0; first_err = -1;
      while (t < 150 && first_err < 0) begin
         @(negedge clk);
         t++;
         if (err === 1'b1) first_err = t;
      end
      n_checks++; if (first_err < TO || first_err > TO + 4) begin n_errors++; $display("FAIL timeout_err_cycle got=%0d exp %0d..%0d", first_err, TO, TO + 4); end
      n_checks++; if (bus.pix_ready !== 1'b1) begin n_errors++; $display("FAIL timeout_back_to_fill ready=%b exp 1", bus.pix_ready); end
      nm_auto = 1'b1; nm_delay = 7;
      push_pixel(next_val(1'b0));
      n_checks++; if (bus.start_ !== 1'b1 || win_row !== 3'd2 || win_col !== 3'd3) begin n_errors++; $display("FAIL timeout_next_window start=%b at %0d,%0d exp 1 at 2,3", bus.start_, win_row, win_col); end
      n_checks++; if (cur_win() !== exp_q[exp_q.size()-1].w) begin n_errors++; $display("FAIL timeout_next_data got w8=%h exp w8=%h", bus.win_8, exp_q[exp_q.size()-1].w[8*DW +: DW]); end
      send_pixels(rem_pixels(), 1'b0, 0);
      wait_frame_done(f0 + 1);
      n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL timeout_err_sticky got=%b exp 1", err); end
      mism = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      n_checks++; if (mism !== 0 || n_fd - f0 !== 1) begin n_errors++; $display("FAIL timeout_frame got mism=%0d fd=%0d exp 0,1", mism, n_fd - f0); end
   endtask

   task automatic test_rst_mid();
      int s0, f0, mism;
      nm_auto = 1'b1; nm_delay = 30;
      send_pixels(2 * W + 3, 1'b0, 0);
      repeat (5) @(negedge clk);
      n_checks++; if (bus.pix_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_in_wait ready=%b exp 0", bus.pix_ready); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.pix_ready !== 1'b0 || bus.start_ !== 1'b0) begin n_errors++; $display("FAIL rstmid_during ready=%b start=%b exp 0,0", bus.pix_ready, bus.start_); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.pix_ready !== 1'b1 || bus.start_ !== 1'b0) begin n_errors++; $display("FAIL rstmid_after ready=%b start=%b exp 1,0", bus.pix_ready, bus.start_); end
      n_checks++; if (win_row !== 3'd0 || win_col !== 3'd0 || err !== 1'b0 || bus.win_4 !== '0) begin n_errors++; $display("FAIL rstmid_values row=%0d col=%0d err=%b win4=%h exp 0", win_row, win_col, err, bus.win_4); end
      @(negedge clk);
      pos_r = 0; pos_c = 0;
      obs_q.delete(); exp_q.delete();
      s0 = n_start; f0 = n_fd;
      nm_delay = 11;
      send_pixels(W * H, 1'b0, 0);
      wait_frame_done(f0 + 1);
      mism = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      n_checks++; if (n_start - s0 !== 36 || n_fd - f0 !== 1) begin n_errors++; $display("FAIL rstmid_fresh_counts starts=%0d fd=%0d exp 36,1", n_start - s0, n_fd - f0); end
      n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL rstmid_fresh_windows mism=%0d exp 0", mism); end
   endtask

   task automatic test_back_to_back();
      int s0, f0, mism;
      obs_q.delete(); exp_q.delete();
      s0 = n_start; f0 = n_fd;
      nm_auto = 1'b1;
      nm_delay = $urandom_range(2, 15);
      send_pixels(W * H, 1'b0, 3);
      nm_delay = $urandom_range(2, 15);
      send_pixels(W * H, 1'b1, 3);
      wait_frame_done(f0 + 2);
      n_checks++; if (n_start - s0 !== 72) begin n_errors++; $display("FAIL b2b_start_count got=%0d exp=72", n_start - s0); end
      n_checks++; if (n_fd - f0 !== 2) begin n_errors++; $display("FAIL b2b_frame_done got=%0d exp=2", n_fd - f0); end
      n_checks++;
      if (obs_q.size() <= 36) begin
         n_errors++; $display("FAIL b2b_second_first got=missing exp w8=18");
      end else if (obs_q[36].w[8*DW +: DW] !== DW'(18)) begin
         n_errors++; $display("FAIL b2b_second_first got w8=%0d exp w8=18", obs_q[36].w[8*DW +: DW]);
      end
      mism = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      n_checks++; if (mism !== 0) begin n_errors++; $display("FAIL b2b_windows mism=%0d exp 0", mism); end
   endtask

   initial begin
      bus.pix_in    = '0;
      bus.pix_valid = 1'b0;
      test_reset();
      test_ramp_frame();
      test_stall();
      test_stale_end();
      test_timeout();
      test_rst_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
